// File: rtl/ram_loader_ctrl.sv
// Program loader for the 16-byte RAM. It accepts bytes over a valid/ready handshake.
// Each byte is pushed onto the shared bus in three steps: address into MAR, data into
// MAR, then a RAM write strobe. The CPU control block is held idle while the loader
// owns the bus, and is released once the program has been loaded.
module ram_loader_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              n_lma,
    output logic              n_lmd,
    output logic              n_we,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_DRV_ADDR,
        S_DRV_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] byte_q,  byte_d;
    logic              last_q,  last_d;

    // State, address and count registers; the latched byte is plain data and is not reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
        byte_q <= byte_d;
    end

    // Next-state logic: one byte takes WAIT_BYTE -> DRV_ADDR -> DRV_DATA -> WRITE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        byte_d  = byte_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT_BYTE;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            S_WAIT_BYTE: begin
                // byte_ready is high throughout this state, so valid alone completes the handshake
                if (byte_valid) begin
                    byte_d  = byte_in;
                    last_d  = byte_last;
                    state_d = S_DRV_ADDR;
                end
            end
            S_DRV_ADDR: state_d = S_DRV_DATA;
            S_DRV_DATA: state_d = S_WRITE;
            S_WRITE: begin
                count_d = count_q + 1'b1;
                // The top address always ends the load, so addr never wraps to 0
                if (last_q || (addr_q == ADDR_MAX)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_WAIT_BYTE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register only, so no input reaches them combinationally
    always_comb begin
        byte_ready = 1'b0;
        bus_out    = '0;
        bus_drive  = 1'b0;
        n_lma      = 1'b1;
        n_lmd      = 1'b1;
        n_we       = 1'b1;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_WAIT_BYTE: byte_ready = 1'b1;
            S_DRV_ADDR: begin
                bus_drive = 1'b1;
                bus_out   = DATA_W'(addr_q);
                n_lma     = 1'b0;
            end
            S_DRV_DATA: begin
                bus_drive = 1'b1;
                bus_out   = byte_q;
                n_lmd     = 1'b0;
            end
            S_WRITE: n_we = 1'b0;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            default: ;
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Directed and randomized bench for ram_loader_ctrl. A small bus model emulates MAR and
// the RAM from the strobes; expected RAM contents, count and done come from the list of
// bytes offered to the loader.
module tb_ram_loader_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       byte_ready;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       n_lma, n_lmd, n_we;
    logic       cpu_hold, done;
    logic [4:0] count;

    ram_loader_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .bus_out(bus_out), .bus_drive(bus_drive),
        .n_lma(n_lma), .n_lmd(n_lmd), .n_we(n_we),
        .cpu_hold(cpu_hold), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Bus/RAM model fed by the strobes
    int         cyc = 0;
    int         lma_cyc = -1, lmd_cyc = -1, we_cyc = -1;
    int         we_cnt = 0;
    int         viol = 0;
    logic [3:0] mar_a = '0;
    logic [7:0] mar_d = '0;
    logic [3:0] last_wa = '0;
    logic [7:0] last_wd = '0;
    logic [7:0] ram [16];

    // Reference model of the load in progress
    int         m_cnt = 0;
    bit         m_done = 1'b0;
    logic [7:0] exp_ram [16];
    int         prev_hs = 0;
    bit         chk_tp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!n_lma) begin
            mar_a = bus_out[3:0];
            lma_cyc = cyc;
            if (bus_out[7:4] != 4'h0) viol++;
        end
        if (!n_lmd) begin
            mar_d = bus_out;
            lmd_cyc = cyc;
        end
        if (!n_we) begin
            ram[mar_a] = mar_d;
            last_wa = mar_a;
            last_wd = mar_d;
            we_cyc = cyc;
            we_cnt++;
        end
        if ((int'(!n_lma) + int'(!n_lmd) + int'(!n_we)) > 1) viol++;
        if (bus_drive !== (!n_lma || !n_lmd)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_cnt = 0;
        m_done = 1'b0;
        chk("start_count", count, 0);
        chk("start_done", done, 0);
        chk("start_hold", cpu_hold, 1);
        chk("start_ready", byte_ready, 1);
    endtask

    // Offer one byte after `gap` idle cycles; optionally keep valid high and poke start mid-byte
    task automatic send(input logic [7:0] b, input bit last, input int gap,
                        input bit hold, input bit poke);
        bit got;
        int hs;
        int exp_addr;
        byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            start = (poke && i == 0);
        end
        start = 1'b0;
        if (gap >= 2)
            chk("wait_quiet", {byte_ready, bus_drive, n_lma, n_lmd, n_we}, 5'b10111);
        byte_in = b;
        byte_last = last;
        byte_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (byte_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake", got, 1);
        hs = cyc;
        if (chk_tp) chk("throughput", hs - prev_hs, 4);
        prev_hs = hs;
        exp_addr = m_cnt;
        exp_ram[exp_addr] = b;
        m_cnt++;
        m_done = last || (m_cnt == 16);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!hold && k == 0) byte_valid = 1'b0;
            start = (poke && k == 0);
        end
        start = 1'b0;
        chk("lma_time", lma_cyc, hs + 1);
        chk("lmd_time", lmd_cyc, hs + 2);
        chk("we_time", we_cyc, hs + 3);
        chk("wr_addr", last_wa, exp_addr);
        chk("wr_data", last_wd, b);
        chk("count", count, m_cnt);
        chk("done", done, m_done);
        chk("ready", byte_ready, !m_done);
        chk("cpu_hold", cpu_hold, !m_done);
    endtask

    task automatic chk_ram(input int n);
        for (int i = 0; i < n; i++) chk("ram", {i[7:0], ram[i]}, {i[7:0], exp_ram[i]});
    endtask

    initial begin
        int w;
        int len;
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {byte_ready, bus_drive, n_lma, n_lmd, n_we, cpu_hold, done}, 7'b0011110);
        chk("rst_bus", bus_out, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_stays", {byte_ready, cpu_hold, done}, 3'b010);

        // Three-byte program, with a start pulse during the second byte
        do_start();
        send(8'h1A, 1'b0, $urandom_range(0, 3), 1'b0, 1'b0);
        send(8'h2B, 1'b0, 2, 1'b0, 1'b1);
        send(8'h3C, 1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
        chk_ram(3);

        // Restart from DONE, then 16 bytes with byte_last never set
        do_start();
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 1'b0, $urandom_range(0, 3), 1'b0, 1'b0);
        w = we_cnt;
        byte_valid = 1'b1;
        byte_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_17th", {byte_ready, done}, 2'b01);
        end
        byte_valid = 1'b0;
        chk("no_17th_write", we_cnt, w);
        chk("count16", count, 16);
        chk_ram(16);

        // Valid held high continuously
        do_start();
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), (i == 5), 0, 1'b1, 1'b0);
            chk_tp = 1'b1;
        end
        chk_tp = 1'b0;
        byte_valid = 1'b0;
        chk_ram(6);

        // Long gaps between bytes
        do_start();
        for (int i = 0; i < 3; i++)
            send(8'($urandom), (i == 2), 5, 1'b0, 1'b0);
        chk_ram(3);

        // Reset during DRV_DATA of the second byte
        do_start();
        send(8'h5A, 1'b0, 1, 1'b0, 1'b0);
        w = we_cnt;
        byte_in = 8'hC3;
        byte_valid = 1'b1;
        for (int n = 0; n < 50 && byte_ready !== 1'b1; n++) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t5_lma", n_lma, 0);
        @(negedge clk);
        chk("t5_lmd", n_lmd, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ctrl", {byte_ready, bus_drive, n_lma, n_lmd, n_we, cpu_hold, done}, 7'b0011110);
        chk("t5_count", count, 0);
        chk("t5_no_write", we_cnt, w);
        chk("t5_ram_kept", ram[0], 8'h5A);

        // Random program lengths, some longer than the RAM
        for (int r = 0; r < 3; r++) begin
            do_start();
            len = $urandom_range(1, 18);
            for (int i = 0; i < len && !m_done; i++)
                send(8'($urandom), (i == len - 1), $urandom_range(0, 2), 1'b0, 1'b0);
            chk("rand_done", done, 1);
            chk_ram(m_cnt);
        end

        chk("bus_rules", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
